// File: rtl/step_pul_gen.sv
// step_pul_gen: STEP/DIR pulse generator; define PUL_DIR_SETUP_EN to insert a DIR-to-STEP setup delay on direction changes
module step_pul_gen #(
  parameter int CNT_W      = 32,
  parameter int MIN_PERIOD = 4,
  parameter int DIR_SETUP  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pul_data,
  input  logic             pul_dir,
  output logic             pul_out,
  output logic             dir_out,
  output logic             done,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, SETUP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, p_q, p_d, h_q, h_d, p_req;
  logic dir_q, dir_d, pul_q, pul_d, done_q, done_d, busy_q, busy_d;
  logic last, latch, dir_chg;
  assign p_req = (pul_data < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : pul_data;
  assign last  = cnt_q == CNT_W'(1);
  assign latch = start && pul_data != '0 && (state_q == IDLE || (state_q == LOW && last));
`ifdef PUL_DIR_SETUP_EN
  assign dir_chg = pul_dir != dir_q;
`else
  assign dir_chg = 1'b0;
`endif
  // state, counter, latched period and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      h_q     <= '0;
      dir_q   <= 1'b0;
      pul_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      h_q     <= h_d;
      dir_q   <= dir_d;
      pul_q   <= pul_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
  // next state: latch a new period at IDLE or at the last LOW cycle, otherwise count phases down to 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    p_d     = p_q;
    h_d     = h_q;
`ifdef PUL_DIR_SETUP_EN
    dir_d   = dir_q;
`else
    dir_d   = pul_dir;
`endif
    if (latch) begin
      p_d     = p_req;
      h_d     = p_req >> 1;
      state_d = dir_chg ? SETUP : HIGH;
      cnt_d   = dir_chg ? CNT_W'(DIR_SETUP) : p_req >> 1;
      if (dir_chg) dir_d = pul_dir;
    end else begin
      case (state_q)
        IDLE:  cnt_d = '0;
        HIGH:  if (last) begin state_d = LOW;  cnt_d = p_q - h_q; end
        LOW:   if (last) begin state_d = IDLE; cnt_d = '0;        end
        SETUP: if (last) begin state_d = HIGH; cnt_d = h_q;       end
      endcase
    end
  end
  // outputs decoded from the next state so they appear registered alongside it
  always_comb begin
    pul_d  = state_d == HIGH;
    done_d = state_d == LOW && cnt_d == CNT_W'(1);
    busy_d = state_d != IDLE;
  end
  assign pul_out = pul_q;
  assign dir_out = dir_q;
  assign done    = done_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_step_pul_gen.sv
// tb_step_pul_gen: randomized and directed checks of step_pul_gen against a period-position reference model
module tb_step_pul_gen;
  localparam int MINP = 4;
  localparam int DSET = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pul_dir = 1'b0;
  logic [31:0] pul_data = '0;
  logic pul_out, dir_out, done, busy;
  int n_tests = 0, n_fail = 0;
  bit m_act = 0;
  int m_p = 0, m_h = 0, m_pos = 0, m_setup = 0;
  logic m_dir = 1'b0;
  step_pul_gen #(.CNT_W(32), .MIN_PERIOD(MINP), .DIR_SETUP(DSET)) dut (
    .clk(clk), .rst(rst), .start(start), .pul_data(pul_data), .pul_dir(pul_dir),
    .pul_out(pul_out), .dir_out(dir_out), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic [31:0] d, input logic dr);
    bit boundary;
    int p;
    @(negedge clk);
    rst = r; start = s; pul_data = d; pul_dir = dr;
    @(posedge clk);
    boundary = !m_act || (m_setup == 0 && m_pos == m_p - 1);
    if (r) begin
      m_act = 0; m_setup = 0; m_pos = 0; m_dir = 1'b0;
    end else begin
`ifndef PUL_DIR_SETUP_EN
      m_dir = dr;
`endif
      if (boundary && s && d != 0) begin
        p = (d < MINP) ? MINP : int'(d);
        m_p = p; m_h = p / 2; m_pos = 0; m_act = 1; m_setup = 0;
`ifdef PUL_DIR_SETUP_EN
        if (dr != m_dir) begin m_dir = dr; m_setup = DSET; end
`endif
      end else if (boundary) m_act = 0;
      else if (m_setup > 0) m_setup--;
      else m_pos++;
    end
    #1;
    check("pul_out", 32'(pul_out), 32'(m_act && m_setup == 0 && m_pos < m_h));
    check("done", 32'(done), 32'(m_act && m_setup == 0 && m_pos == m_p - 1));
    check("busy", 32'(busy), 32'(m_act));
    check("dir_out", 32'(dir_out), 32'(m_dir));
  endtask
  initial begin
    int r;
    repeat (2) step(1, 0, 0, 0);
    repeat (35) step(0, 1, 10, 0);
    repeat (20) step(0, 1, 7, 0);
    repeat (12) step(0, 1, 3, 0);
    repeat (10) step(0, 1, 0, 0);
    repeat (3) step(0, 1, 10, 0);
    repeat (40) step(0, 1, 20, 0);
    repeat (3) step(0, 1, 10, 0);
    repeat (15) step(0, 0, 10, 0);
    repeat (7) step(0, 1, 10, 0);
    step(1, 1, 10, 0);
    repeat (12) step(0, 1, 10, 0);
    repeat (30) step(0, 1, 10, 1);
    repeat (25) step(0, 1, 10, 0);
    repeat (3000) begin
      r = int'($urandom_range(0, 99));
      step(r < 1, r < 85, (r % 9 == 0) ? 32'd0 : 32'($urandom_range(1, 25)), ($urandom_range(0, 15) == 0) ? ~pul_dir : pul_dir);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
